// File: rtl/keypoint_scan_ctrl.sv
// Row sequencer for the SIFT keypoint stage: steps the pyramid row address, shifts line buffers,
// and serialises border-masked keypoint flags of every scale into per-scale keypoint SRAM writes.
module keypoint_scan_ctrl #(
    parameter int ROWS       = 480,
    parameter int COLS       = 640,
    parameter int NUM_SCALES = 2,
    parameter int BORDER     = 1,
    parameter int ROW_W      = 9,
    parameter int COL_W      = 10,
    parameter int KP_AW      = 11,
    parameter int KP_DEPTH   = 2048
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [ROW_W-1:0]                    row_addr,
    output logic                                buf_we,
    input  logic [NUM_SCALES*COLS-1:0]          kp_flags,
    output logic [NUM_SCALES-1:0]               kp_we,
    output logic [NUM_SCALES*KP_AW-1:0]         kp_addr,
    output logic [NUM_SCALES*(ROW_W+COL_W)-1:0] kp_din,
    output logic [NUM_SCALES*(KP_AW+1)-1:0]     kp_count,
    output logic [NUM_SCALES-1:0]               overflow,
    output logic [2:0]                          state_dbg
);

    localparam int DIN_W = ROW_W + COL_W;
    localparam int CNT_W = KP_AW + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(KP_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic [COLS-1:0] col_mask_f();
        logic [COLS-1:0] m;
        m = '0;
        for (int c = 0; c < COLS; c++) begin
            if (c >= BORDER && c <= COLS - 1 - BORDER) m[c] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [COLS-1:0] COL_MASK = col_mask_f();

    state_t                         state_q, state_d;
    logic [NUM_SCALES*COLS-1:0]     pending_q;
    logic [NUM_SCALES*COLS-1:0]     lsb;
    logic [NUM_SCALES-1:0]          sel_valid;
    logic [NUM_SCALES-1:0]          can_write;
    logic [COL_W-1:0]               sel_col [NUM_SCALES];
    logic [CNT_W-1:0]               cnt_a   [NUM_SCALES];
    logic                           any_pending;
    logic                           last_row;
    logic                           row_ok;
    logic [ROW_W-1:0]               row_m1;

    // start/busy: start is a request that is taken only when the controller sits in IDLE;
    // any start seen in another state is dropped, never queued.
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign buf_we    = (state_q == ST_SHIFT);
    assign state_dbg = state_q;

    assign any_pending = |pending_q;
    assign last_row    = (row_addr == ROW_W'(ROWS - 1));
    assign row_m1      = row_addr - ROW_W'(1);
    // Fetch row r carries centre row r-1, so the centre-row window shifts up by one.
    assign row_ok      = (row_addr >= ROW_W'(BORDER + 1)) && (row_addr <= ROW_W'(ROWS - BORDER));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_SCAN;
            ST_SCAN:  if (!any_pending) state_d = ST_SHIFT;
            ST_SHIFT: state_d = last_row ? ST_DONE : ST_FETCH;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Lowest set pending bit per scale, isolated as p & -p, then encoded to a column index.
    always_comb begin
        lsb       = '0;
        sel_valid = '0;
        can_write = '0;
        for (int s = 0; s < NUM_SCALES; s++) begin
            sel_col[s] = '0;
            cnt_a[s]   = kp_count[s*CNT_W +: CNT_W];
            lsb[s*COLS +: COLS] = pending_q[s*COLS +: COLS] &
                                  (~pending_q[s*COLS +: COLS] + COLS'(1));
            sel_valid[s] = |pending_q[s*COLS +: COLS];
            can_write[s] = sel_valid[s] && (cnt_a[s] < DEPTH_C);
            for (int c = 0; c < COLS; c++) begin
                if (lsb[s*COLS + c]) sel_col[s] = sel_col[s] | COL_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_addr  <= '0;
            pending_q <= '0;
            kp_we     <= '0;
            kp_addr   <= '0;
            kp_din    <= '0;
            kp_count  <= '0;
            overflow  <= '0;
        end else begin
            kp_we <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        row_addr <= '0;
                        kp_count <= '0;
                        kp_addr  <= '0;
                        overflow <= '0;
                    end
                end
                ST_WAIT: begin
                    pending_q <= row_ok ? (kp_flags & {NUM_SCALES{COL_MASK}}) : '0;
                end
                ST_SCAN: begin
                    pending_q <= pending_q & ~lsb;
                    for (int s = 0; s < NUM_SCALES; s++) begin
                        if (can_write[s]) begin
                            kp_we[s]                    <= 1'b1;
                            kp_addr[s*KP_AW +: KP_AW]   <= cnt_a[s][KP_AW-1:0];
                            kp_din[s*DIN_W +: DIN_W]    <= {row_m1, sel_col[s]};
                            kp_count[s*CNT_W +: CNT_W]  <= cnt_a[s] + CNT_W'(1);
                        end else if (sel_valid[s]) begin
                            overflow[s] <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!last_row) row_addr <= row_addr + ROW_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// Bench for keypoint_scan_ctrl on an 8x16 two-scale frame: table of frame patterns with
// hand-derived results, random frames against a per-frame reference model, and a mid-frame reset.
module tb_keypoint_scan_ctrl;

    localparam int ROWS = 8, COLS = 16, NS = 2, BORDER = 1;
    localparam int ROW_W = 3, COL_W = 4, KP_AW = 2, KP_DEPTH = 4;
    localparam int DIN_W = ROW_W + COL_W, CNT_W = KP_AW + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  busy, done, buf_we;
    logic [ROW_W-1:0]      row_addr;
    logic [NS*COLS-1:0]    kp_flags;
    logic [NS-1:0]         kp_we, overflow;
    logic [NS*KP_AW-1:0]   kp_addr;
    logic [NS*DIN_W-1:0]   kp_din;
    logic [NS*CNT_W-1:0]   kp_count;
    logic [2:0]            state_dbg;

    logic [NS*COLS-1:0]    flags_mem [ROWS];
    assign kp_flags = flags_mem[row_addr];

    keypoint_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .NUM_SCALES(NS), .BORDER(BORDER),
        .ROW_W(ROW_W), .COL_W(COL_W), .KP_AW(KP_AW), .KP_DEPTH(KP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .row_addr(row_addr), .buf_we(buf_we), .kp_flags(kp_flags), .kp_we(kp_we),
        .kp_addr(kp_addr), .kp_din(kp_din), .kp_count(kp_count), .overflow(overflow),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model results: expected writes per scale with their cycle, SHIFT cycles, totals.
    logic [DIN_W-1:0] exp_q0[$], exp_q1[$];
    int               expc_q0[$], expc_q1[$];
    int               exp_shift [ROWS];
    int               exp_cnt [NS];
    logic [NS-1:0]    exp_ovf;

    typedef struct {
        logic [7:0]  rows;
        logic [15:0] s0;
        logic [15:0] s1;
        int          cnt0;
        int          cnt1;
        logic [1:0]  ovf;
        int          done_cyc;
        int          extra;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic build_model();
        int t, kmax, k, rs;
        exp_q0.delete(); exp_q1.delete(); expc_q0.delete(); expc_q1.delete();
        exp_cnt[0] = 0; exp_cnt[1] = 0; exp_ovf = '0;
        t = 0;
        for (int r = 0; r < ROWS; r++) begin
            rs = t + 1;
            kmax = 0;
            for (int s = 0; s < NS; s++) begin
                k = 0;
                if (r - 1 >= BORDER && r - 1 <= ROWS - 1 - BORDER) begin
                    for (int c = BORDER; c <= COLS - 1 - BORDER; c++) begin
                        if (flags_mem[r][s*COLS + c]) begin
                            if (exp_cnt[s] < KP_DEPTH) begin
                                if (s == 0) begin
                                    exp_q0.push_back({ROW_W'(r - 1), COL_W'(c)});
                                    expc_q0.push_back(rs + 3 + k);
                                end else begin
                                    exp_q1.push_back({ROW_W'(r - 1), COL_W'(c)});
                                    expc_q1.push_back(rs + 3 + k);
                                end
                                exp_cnt[s]++;
                            end else begin
                                exp_ovf[s] = 1'b1;
                            end
                            k++;
                        end
                    end
                end
                if (k > kmax) kmax = k;
            end
            t += 4 + kmax;
            exp_shift[r] = t;
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int r = 0; r < ROWS; r++) flags_mem[r] = v.rows[r] ? {v.s1, v.s0} : '0;
    endtask

    task automatic check_write(input int s, input int n, inout int idx);
        logic [DIN_W-1:0] e;
        int ec;
        if ((s == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            chk(s == 0 ? "kp_unexpected0" : "kp_unexpected1", int'(kp_din[s*DIN_W +: DIN_W]), -1);
        end else begin
            if (s == 0) begin e = exp_q0.pop_front(); ec = expc_q0.pop_front(); end
            else        begin e = exp_q1.pop_front(); ec = expc_q1.pop_front(); end
            chk(s == 0 ? "kp_din0" : "kp_din1", int'(kp_din[s*DIN_W +: DIN_W]), int'(e));
            chk(s == 0 ? "kp_addr0" : "kp_addr1", int'(kp_addr[s*KP_AW +: KP_AW]), idx);
            chk(s == 0 ? "kp_cyc0" : "kp_cyc1", n, ec);
            idx++;
        end
    endtask

    task automatic run_frame(input int extra_start, output int done_cyc);
        int nshift, idx0, idx1;
        int got_shift [ROWS];
        int got_row [ROWS];
        bit done_seen;
        build_model();
        nshift = 0; idx0 = 0; idx1 = 0; done_seen = 0; done_cyc = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 1000 && !done_seen; n++) begin
            @(negedge clk);
            start = (n == extra_start);
            if (n == 1) chk("busy_run", busy, 1);
            if (buf_we && nshift < ROWS) begin
                got_shift[nshift] = n;
                got_row[nshift]   = row_addr;
                nshift++;
            end
            if (kp_we[0]) check_write(0, n, idx0);
            if (kp_we[1]) check_write(1, n, idx1);
            if (done) begin done_seen = 1; done_cyc = n; end
        end
        start = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("shift_count", nshift, ROWS);
        for (int r = 0; r < nshift; r++) begin
            chk("shift_cyc", got_shift[r], exp_shift[r]);
            chk("shift_row", got_row[r], r);
        end
        chk("done_cyc", done_cyc, exp_shift[ROWS-1] + 1);
        chk("missing_wr0", exp_q0.size(), 0);
        chk("missing_wr1", exp_q1.size(), 0);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_state", state_dbg, 0);
        chk("kp_count0", kp_count[0 +: CNT_W], exp_cnt[0]);
        chk("kp_count1", kp_count[CNT_W +: CNT_W], exp_cnt[1]);
        chk("overflow", overflow, exp_ovf);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, state_dbg, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_buf_we"}, buf_we, 0);
        chk({tag, "_row_addr"}, row_addr, 0);
        chk({tag, "_kp_we"}, kp_we, 0);
        chk({tag, "_kp_addr"}, kp_addr, 0);
        chk({tag, "_kp_din"}, kp_din, 0);
        chk({tag, "_kp_count"}, kp_count, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        int dc;
        bit found;
        vec_t rv;

        //           rows    s0        s1        c0 c1 ovf    done extra
        vecs[0] = '{8'hFF, 16'h0000, 16'h0000, 0, 0, 2'b00, 33,  0};
        vecs[1] = '{8'hFF, 16'hFFFF, 16'hFFFF, 4, 4, 2'b11, 117, 0};
        vecs[2] = '{8'h08, 16'h0208, 16'h0020, 2, 1, 2'b00, 35,  0};
        vecs[3] = '{8'hFF, 16'h8001, 16'h8001, 0, 0, 2'b00, 33,  0};
        vecs[4] = '{8'h03, 16'hFFFF, 16'hFFFF, 0, 0, 2'b00, 33,  0};
        vecs[5] = '{8'h80, 16'h0002, 16'h0000, 1, 0, 2'b00, 34,  0};
        vecs[6] = '{8'h24, 16'h4002, 16'h000E, 4, 4, 2'b10, 39,  0};
        vecs[7] = '{8'hFF, 16'h0000, 16'h0000, 0, 0, 2'b00, 33,  10};

        for (int r = 0; r < ROWS; r++) flags_mem[r] = '0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            load_vec(vecs[i]);
            run_frame(vecs[i].extra, dc);
            chk("tbl_done_cyc", dc, vecs[i].done_cyc);
            chk("tbl_cnt0", kp_count[0 +: CNT_W], vecs[i].cnt0);
            chk("tbl_cnt1", kp_count[CNT_W +: CNT_W], vecs[i].cnt1);
            chk("tbl_ovf", overflow, vecs[i].ovf);
        end

        // Reset while scanning fetch row 3 of a dense frame, then a clean frame.
        load_vec(vecs[1]);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 0;
        for (int n = 0; n < 500 && !found; n++) begin
            @(negedge clk);
            if (row_addr == 3'd3 && state_dbg == 3'd3) found = 1;
        end
        chk("rst_scan_found", found, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 check_all_zero("midrst");
        @(negedge clk) rst = 1'b0;
        load_vec(vecs[2]);
        run_frame(0, dc);
        chk("post_rst_cnt0", kp_count[0 +: CNT_W], 2);

        // Random frames, sparse and dense, checked against the model.
        for (int f = 0; f < 6; f++) begin
            for (int r = 0; r < ROWS; r++) begin
                flags_mem[r] = '0;
                for (int b = 0; b < NS*COLS; b++)
                    flags_mem[r][b] = ($urandom_range(0, (f < 3) ? 7 : 2) == 0);
            end
            run_frame((f % 2 == 1) ? int'($urandom_range(2, 30)) : 0, dc);
        end

        rv = vecs[0];
        load_vec(rv);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
